// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Shift-add multiply, restoring divide, one bit per cycle plus a fix-up cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_div;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mthi;
  logic               w_is_mtlo;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_last;

  assign w_is_mul  = start & (op[2:1] == 2'b00);
  assign w_is_div  = start & (op[2:1] == 2'b01);
  assign w_is_mthi = start & (op == 3'b100);
  assign w_is_mtlo = start & (op == 3'b101);
  assign w_signed  = ~op[0];

  assign w_mag_a = (w_signed & rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign w_mag_b = (w_signed & rt_i[WIDTH-1]) ? -rt_i : rt_i;

  // multiply: r_prod = {partial sum, remaining multiplier bits}
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
               + (r_prod[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_prod[WIDTH-1:1]};

  // divide: r_prod = {partial remainder, dividend/quotient bits}
  assign w_rem_sh = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH]
    ? {w_rem_sh[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
    : {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH]
                              : r_prod[2*WIDTH-1:WIDTH];
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_b     <= '0;
      r_rs    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_div   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_neg_q <= w_signed & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
          r_neg_r <= w_signed & rs_i[WIDTH-1];
          r_rs    <= rs_i;
          r_dz    <= (rt_i == '0);
          unique case (1'b1)
            w_is_mul: begin
              r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
              r_b     <= w_mag_a;
              r_div   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end
            w_is_div: begin
              r_prod  <= {{WIDTH{1'b0}}, w_mag_a};
              r_b     <= w_mag_b;
              r_div   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_DIV;
            end
            w_is_mthi: r_hi <= rs_i;
            w_is_mtlo: r_lo <= rs_i;
            default: ;
          endcase
        end
        S_MUL: begin
          r_prod <= w_mul_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_DIV: begin
          r_prod <= w_div_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_div) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (r_dz) begin
            // divide by zero reports the raw dividend, not its magnitude
            r_hi <= r_rs;
            r_lo <= {WIDTH{1'b1}};
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, queue of expected HI/LO
// popped by a monitor on every done pulse.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs_i  (rs_i),
    .rt_i  (rt_i),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_hi", hi_o, e.hi);
        check("sb_lo", lo_o, e.lo);
      end
    end
  end

  // called at a negedge; returns at the negedge where done is high
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input int poke_at);
    int cyc;
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb_q.push_back(e);
    m_hi = eh;
    m_lo = el;
    start = 1'b1;
    op    = o;
    rs_i  = a;
    rt_i  = b;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      if (cyc == poke_at) begin
        start = 1'b1;
        op    = 3'b000;
        rs_i  = 32'd3;
        rt_i  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", cyc, 32'd33);
    check("done_at_end", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 3'b000;
    rs_i   = '0;
    rt_i   = '0;
    m_hi   = '0;
    m_lo   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, -1);

    @(negedge clk);
    start = 1'b1;
    op    = 3'b100;
    rs_i  = 32'h1234_5678;
    @(negedge clk);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi_o, 32'h1234_5678);
    op   = 3'b101;
    rs_i = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_lo", lo_o, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi_o, 32'h1234_5678);

    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op(3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, -1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, -1);
    run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op(3'b000, 32'd6, 32'd7, 32'd0, 32'd42, -1);

    // flush part-way through a MULT
    start = 1'b1;
    op    = 3'b000;
    rs_i  = 32'd9;
    rt_i  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", hi_o, m_hi);
    check("flush_lo", lo_o, m_lo);

    start = 1'b1;
    flush = 1'b1;
    op    = 3'b100;
    rs_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_mthi_hi", hi_o, m_hi);
    check("flush_mthi_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of a DIV
    start = 1'b1;
    op    = 3'b010;
    rs_i  = 32'd50;
    rt_i  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_hi", hi_o, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, -1);

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the EX stage of the MIPS pipeline. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. Its `busy` output is the stall source for the IF/ID and ID/EX pipeline latches: their write enable is driven by `~busy`. MFHI/MFLO read `hi_o`/`lo_o` combinationally into the EX/MEM latch.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `start`  input  1  issue request; sampled at posedge only while `busy`=0.
- `op`  input  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111 are no-ops.
- `rs_i`  input  WIDTH  operand A (multiplicand/dividend; MTHI/MTLO source).
- `rt_i`  input  WIDTH  operand B (multiplier/divisor).
- `flush`  input  1  cancels any in-flight operation.
- `busy`  output  1  iterative operation in progress.
- `done`  output  1  one-cycle pulse; HI/LO hold a new mul/div result.
- `hi_o`  output  WIDTH  HI register.
- `lo_o`  output  WIDTH  LO register.

## Operation
- States:
  - IDLE: accepts `start`.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring, one quotient bit per cycle.
  - FIX: sign correction and HI/LO write.
- Iteration counter: `$clog2(WIDTH)+1` bits; MUL and DIV each run exactly WIDTH iterations.
- IDLE with `start`=1 and `flush`=0:
  - MULT/MULTU → MUL; DIV/DIVU → DIV.
  - Operands are latched at the accepting edge. Signed ops latch magnitudes and record the result signs.
  - MTHI: `hi_o`←`rs_i` at that edge, state stays IDLE, no `busy`, no `done`. MTLO likewise writes `lo_o`.
  - Codes 110/111: no effect.
- MUL: 2·WIDTH-bit unsigned product of the magnitudes.
  - Signed product negated if the signs differ.
  - HI = upper half, LO = lower half.
- DIV: unsigned quotient/remainder of the magnitudes.
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: LO = all ones, HI = `rs_i` as issued (raw value, not magnitude).
- Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm and must not be special-cased.
- `start` while `busy`=1 is ignored. The pipeline holds the instruction stalled and re-presents it.
- `flush`=1:
  - Any state → IDLE at the next edge.
  - HI/LO unchanged, `done` not asserted.
  - `flush` with `start` on the same edge: `flush` wins and nothing is issued, including MTHI/MTLO.
- Reset (asynchronous, any state): state IDLE, `hi_o`=0, `lo_o`=0, `busy`=0, `done`=0, counter 0.

## Timing
- Accepting edge is E0. `busy`=1 from E0 through E(WIDTH+1): WIDTH iteration cycles plus one FIX cycle.
- At E(WIDTH+1):
  - HI/LO are updated.
  - `busy` falls.
  - `done`=1 for exactly one cycle.
- Latency: 33 cycles from issue to visible result at WIDTH=32.
- A new `start` is accepted at E(WIDTH+2) at the earliest, which is the cycle in which `done`=1. Back-to-back throughput is one operation per WIDTH+2 cycles.
- MTHI/MTLO: result visible the cycle after E0, zero stall.
- `busy` and `done` are registered outputs with no combinational path from inputs.
- `hi_o`/`lo_o` change only at an accepting edge (MTHI/MTLO), at a FIX edge, or at reset.

## Test plan
- MULT with `rs_i`=0xFFFFFFFD (-3), `rt_i`=5 → `busy` high for 33 cycles, then `done` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Also check MTHI 0x12345678 followed next cycle by MTLO 0x9ABCDEF0 → both registers set with `busy` never high.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Issue DIVU 100/7, then assert `start` with MULT at cycle 10 → second request ignored; result LO=14, HI=2 at cycle 33. Re-issue MULT in the `done` cycle → accepted.
- Assert `flush` at cycle 15 of a MULT → `busy`=0 next cycle, no `done`, HI/LO keep prior values. `start`+`flush` together with MTHI → HI unchanged.
- Drive `rst` low at cycle 20 of a DIV → `busy`, `done`, `hi_o`, `lo_o` all 0 immediately (asynchronously), and the unit accepts a new op after `rst` is released.
